store_buffer_ctrl: RTL
======================

STORE_BUFFER_CTRL -- requirements
Module: store_buffer_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of queued store entries (power of two, 2..8).
REQ-002 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port st_valid_i  input  1  pipeline presents a formatted store.
REQ-005 SHALL have port st_ready_o  output  1  buffer can accept a store this cycle.
REQ-006 SHALL have ports st_addr_i  input  32, st_wdata_i  input  32, st_wstrb_i  input  4  store word address, lane-aligned data, byte strobes.
REQ-007 SHALL have port mem_valid_o  output  1  write request to data memory.
REQ-008 SHALL have port mem_ready_i  input  1  memory accepts request.
REQ-009 SHALL have port mem_ack_i  input  1  memory write complete, one cycle pulse.
REQ-010 SHALL have ports mem_addr_o  output  32, mem_wdata_o  output  32, mem_wstrb_o  output  4  request payload.
REQ-011 SHALL have port ld_addr_i  input  32  address of pending load for hazard check.
REQ-012 SHALL have port ld_hazard_o  output  1  load must stall.
REQ-013 SHALL have port empty_o  output  1  no queued or in-flight store (fence drain indicator).

Function
REQ-014 SHALL store entries in a circular FIFO with wrapping read/write pointers and a count of width clog2(DEPTH)+1.
REQ-015 SHALL enqueue when st_valid_i && st_ready_o; st_ready_o = count < DEPTH, independent of st_valid_i.
REQ-016 SHALL drop (not enqueue) a store with st_wstrb_i == 0, while still completing the handshake.
REQ-017 SHALL run FSM IDLE -> REQ -> WAIT_ACK -> IDLE; one write outstanding maximum.
REQ-018 IDLE: if count != 0, go REQ next cycle (one-cycle latency from enqueue into empty buffer to mem_valid_o).
REQ-019 REQ: mem_valid_o = 1 with head entry payload held stable; on mem_ready_i go WAIT_ACK.
REQ-020 WAIT_ACK: mem_valid_o = 0; on mem_ack_i pop head, go REQ if remaining count != 0, else IDLE.
REQ-021 mem_ack_i outside WAIT_ACK SHALL be ignored.
REQ-022 Simultaneous enqueue and pop SHALL leave count unchanged; enqueue when full SHALL not occur because st_ready_o = 0.
REQ-023 mem_addr_o SHALL have bits [1:0] forced to 0; mem_addr_o, mem_wdata_o, mem_wstrb_o SHALL be 0 outside REQ.
REQ-024 empty_o = (count == 0) && state == IDLE.
REQ-025 ld_hazard_o SHALL be combinational from ld_addr_i and current entries, including the in-flight head until popped.

Reset
REQ-026 On rst_ni low, asynchronously: state IDLE, pointers and count 0, all entries' strobes 0.
REQ-027 Reset values: st_ready_o 1, mem_valid_o 0, mem payload 0, ld_hazard_o 0, empty_o 1.
REQ-028 Reset mid-transaction SHALL abandon the outstanding write; a later mem_ack_i in IDLE is ignored.

Configuration
REQ-029 Macro STBUF_LDHAZARD_EN SHALL select hazard precision.
REQ-030 Defined: ld_hazard_o = 1 iff any valid entry has addr[31:2] == ld_addr_i[31:2].
REQ-031 Undefined: ld_hazard_o = !empty_o (any pending store stalls every load); no address comparators built.

Verification
REQ-032 Single store: enqueue addr 0x100, data 0xDEADBEEF, strb 0xF, mem_ready_i=1, ack 2 cycles later -> mem_valid_o high cycle after enqueue, payload matches, empty_o returns 1 cycle after ack.
REQ-033 Full: DEPTH=2, mem_ready_i=0, three back-to-back stores -> st_ready_o falls after second; third accepted only after first ack; order preserved at mem port.
REQ-034 Hazard: queued store to 0x204, ld_addr_i=0x207 -> ld_hazard_o=1; ld_addr_i=0x208 -> 0 with macro, 1 without.
REQ-035 Simultaneous: buffer full, ack and new store same cycle -> count stays DEPTH-side consistent, st_ready_o 0 then new entry issued last.
REQ-036 Reset in WAIT_ACK with 2 entries -> all outputs at reset values immediately; stray mem_ack_i afterward causes no pop or request.
REQ-037 Zero strobe: store with st_wstrb_i=0 -> handshake completes, no mem_valid_o, empty_o stays 1.

Source files
------------

// File: rtl/store_buffer_ctrl_if.sv
// Bundle of store-pipeline, memory-write and load-hazard signals for store_buffer_ctrl.
// The slave modport is the buffer itself; the master modport is the pipeline/memory side.
interface store_buffer_ctrl_if;
    logic        st_valid_i;
    logic        st_ready_o;
    logic [31:0] st_addr_i;
    logic [31:0] st_wdata_i;
    logic [3:0]  st_wstrb_i;
    logic        mem_valid_o;
    logic        mem_ready_i;
    logic        mem_ack_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] ld_addr_i;
    logic        ld_hazard_o;
    logic        empty_o;

    modport slave (
        input  st_valid_i, st_addr_i, st_wdata_i, st_wstrb_i,
        input  mem_ready_i, mem_ack_i, ld_addr_i,
        output st_ready_o, mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        output ld_hazard_o, empty_o
    );

    modport master (
        output st_valid_i, st_addr_i, st_wdata_i, st_wstrb_i,
        output mem_ready_i, mem_ack_i, ld_addr_i,
        input  st_ready_o, mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        input  ld_hazard_o, empty_o
    );
endinterface

// File: rtl/store_buffer_ctrl.sv
// Store buffer: circular FIFO of pending stores drained one write at a time to data memory.
// Define STBUF_LDHAZARD_EN for address-precise load hazards; otherwise any pending store stalls loads.
module store_buffer_ctrl #(
    parameter int DEPTH = 2
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    store_buffer_ctrl_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK} state_t;

    logic [29:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [3:0]  strb_q [DEPTH];

    ptr_t   wr_ptr, rd_ptr, sel;
    cnt_t   count;
    state_t state;
    logic   push, pop;

    logic        mem_valid_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [3:0]  mem_wstrb_q;

    assign bus.st_ready_o = count < cnt_t'(DEPTH);
    // Zero-strobe stores complete the handshake but never occupy an entry.
    assign push = bus.st_valid_i && bus.st_ready_o && (|bus.st_wstrb_i);
    assign pop  = (state == WAIT_ACK) && bus.mem_ack_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) strb_q[i] <= '0;
        end else begin
            if (push) begin
                strb_q[wr_ptr] <= bus.st_wstrb_i;
                wr_ptr         <= wr_ptr + ptr_t'(1);
            end
            if (pop) rd_ptr <= rd_ptr + ptr_t'(1);
            case ({push, pop})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: address/data storage has no reset; occupancy comes from count, so stale contents are never used.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[wr_ptr] <= bus.st_addr_i[31:2];
            data_q[wr_ptr] <= bus.st_wdata_i;
        end
    end

    // On ack the head is being popped, so the next request comes from the following entry.
    always_comb begin
        sel = rd_ptr;
        if (state == WAIT_ACK) sel = rd_ptr + ptr_t'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state       <= REQ;
                        mem_valid_q <= 1'b1;
                        mem_addr_q  <= {addr_q[sel], 2'b00};
                        mem_wdata_q <= data_q[sel];
                        mem_wstrb_q <= strb_q[sel];
                    end
                end
                REQ: begin
                    if (bus.mem_ready_i) begin
                        state       <= WAIT_ACK;
                        mem_valid_q <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        mem_wstrb_q <= '0;
                    end
                end
                WAIT_ACK: begin
                    if (bus.mem_ack_i) begin
                        if (count != cnt_t'(1)) begin
                            state       <= REQ;
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= {addr_q[sel], 2'b00};
                            mem_wdata_q <= data_q[sel];
                            mem_wstrb_q <= strb_q[sel];
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_valid_o = mem_valid_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.mem_wstrb_o = mem_wstrb_q;
    assign bus.empty_o     = (count == '0) && (state == IDLE);

`ifdef STBUF_LDHAZARD_EN
    ptr_t off;
    logic hazard;
    logic unused_addr_bits;

    // An entry is live while its distance from the read pointer is below count.
    always_comb begin
        hazard = 1'b0;
        off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = ptr_t'(i) - rd_ptr;
            if (({1'b0, off} < count) && (|strb_q[i]) && (addr_q[i] == bus.ld_addr_i[31:2]))
                hazard = 1'b1;
        end
    end

    assign bus.ld_hazard_o = hazard;
    assign unused_addr_bits = ^{bus.ld_addr_i[1:0], bus.st_addr_i[1:0]};
`else
    logic unused_addr_bits;

    assign bus.ld_hazard_o = !bus.empty_o;
    assign unused_addr_bits = ^{bus.ld_addr_i, bus.st_addr_i[1:0]};
`endif
endmodule
